minx16_dbus_target: RTL and testbench

//  Bus target on the Minx16 CPU multiplexed data bus (dbus), directly downstream of cpu16.

---
 rtl/minx16_dbus_pkg.sv | 24 ++
 rtl/minx16_dbus_if.sv | 25 ++
 rtl/minx16_dbus_regfile.sv | 28 ++
 rtl/minx16_dbus_target.sv | 137 +++++++++++++
 tb/tb_minx16_dbus_target.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/minx16_dbus_pkg.sv
// Shared definitions for the Minx16 dbus target: FSM states, strobe bit positions
// and the address-window decode helper.
package minx16_dbus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT,
      ST_ACK
   } dbus_state_t;

   localparam int unsigned STB_LO = 0;
   localparam int unsigned STB_HI = 1;

   // The window spans 2**(addr_w+1) bytes starting at base.
   function automatic logic win_hit(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input int unsigned addr_w);
      logic [15:0] mask;
      mask = 16'((32'd1 << (addr_w + 1)) - 32'd1);
      return (addr & ~mask) == base;
   endfunction

endpackage

// File: rtl/minx16_dbus_if.sv
// Minx16 multiplexed data bus as seen between the CPU (master) and a bus target (slave).
interface minx16_dbus_if;

   logic [15:0] ad_i;
   logic [15:0] ad_o;
   logic [15:0] ad_oeb_o;
   logic        ale_i;
   logic        dle_i;
   logic [1:0]  stb_i;
   logic        rd_i;
   logic        wr_i;
   logic        rdy_o;
   logic        hit_o;

   modport slave (
      input  ad_i, ale_i, dle_i, stb_i, rd_i, wr_i,
      output ad_o, ad_oeb_o, rdy_o, hit_o
   );

   modport master (
      output ad_i, ale_i, dle_i, stb_i, rd_i, wr_i,
      input  ad_o, ad_oeb_o, rdy_o, hit_o
   );

endinterface

// File: rtl/minx16_dbus_regfile.sv
// 2**ADDR_W x 16 register file: synchronous write with per-byte enables,
// combinational read. Contents are not reset.
module minx16_dbus_regfile
   import minx16_dbus_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [1:0]        be,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);

   logic [15:0] mem [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we) begin
         if (be[STB_LO]) mem[waddr][7:0]  <= wdata[7:0];
         if (be[STB_HI]) mem[waddr][15:8] <= wdata[15:8];
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/minx16_dbus_target.sv
// Minx16 dbus target: demultiplexes AD, decodes a fixed window and services
// reads/writes from a register file after WAIT_STATES cycles, completing with rdy.
module minx16_dbus_target
   import minx16_dbus_pkg::*;
#(
   parameter int unsigned ADDR_W      = 4,
   parameter logic [15:0] BASE_ADDR   = 16'hF000,
   parameter int unsigned WAIT_STATES = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   minx16_dbus_if.slave  bus
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   dbus_state_t       state, state_nxt;
   logic [ADDR_W-1:0] idx_q;
   logic              hit_q;
   logic [15:0]       wdata_q;
   logic              vld_q;
   logic [1:0]        stb_q;
   logic              wr_q;
   logic [3:0]        cnt_q;
   logic [15:0]       ad_q;
   logic [15:0]       oeb_q;
   logic              rdy_q;

   logic              accept, commit, release_bus;
   logic [15:0]       rf_rdata;
   logic [15:0]       byte_mask;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // ale_i overrides every state: it aborts the current access and drops the bus.
   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      commit      = 1'b0;
      release_bus = 1'b0;
      if (bus.ale_i) begin
         state_nxt   = ST_ADDR;
         release_bus = 1'b1;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_ADDR: begin
               if (hit_q) begin
                  if (bus.rd_i && !bus.wr_i)
                     accept = 1'b1;
                  else if (bus.wr_i && !bus.rd_i && (vld_q || bus.dle_i))
                     accept = 1'b1;
               end
               if (accept) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_nxt = ST_ACK;
                  commit    = 1'b1;
               end
            end
            ST_ACK: begin
               if (!bus.rd_i && !bus.wr_i) begin
                  state_nxt   = ST_IDLE;
                  release_bus = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign byte_mask = {{8{stb_q[STB_HI]}}, {8{stb_q[STB_LO]}}};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q   <= '0;
         hit_q   <= 1'b0;
         wdata_q <= '0;
         vld_q   <= 1'b0;
         stb_q   <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
         ad_q    <= '0;
         oeb_q   <= '1;
         rdy_q   <= 1'b0;
      end else begin
         if (bus.ale_i) begin
            idx_q <= bus.ad_i[ADDR_W:1];
            hit_q <= win_hit(bus.ad_i, BASE_ADDR, ADDR_W);
            vld_q <= 1'b0;
         end else if (state == ST_ADDR && hit_q && bus.dle_i) begin
            wdata_q <= bus.ad_i;
            vld_q   <= 1'b1;
         end

         if (accept) begin
            stb_q <= bus.stb_i;
            wr_q  <= bus.wr_i;
            cnt_q <= WAIT_CNT;
         end else if (state == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
         end

         if (commit) begin
            rdy_q <= 1'b1;
            if (!wr_q) begin
               ad_q  <= rf_rdata & byte_mask;
               oeb_q <= '0;
            end
         end else if (release_bus) begin
            rdy_q <= 1'b0;
            ad_q  <= '0;
            oeb_q <= '1;
         end
      end
   end

   minx16_dbus_regfile #(.ADDR_W(ADDR_W)) u_regfile (
      .clk_i (clk_i),
      .we    (commit && wr_q),
      .be    (stb_q),
      .waddr (idx_q),
      .wdata (wdata_q),
      .raddr (idx_q),
      .rdata (rf_rdata)
   );

   assign bus.ad_o     = ad_q;
   assign bus.ad_oeb_o = oeb_q;
   assign bus.rdy_o    = rdy_q;
   assign bus.hit_o    = hit_q;

endmodule

// File: tb/tb_minx16_dbus_target.sv
// Bench for minx16_dbus_target: two instances (WAIT_STATES=2 and 0), directed
// scenarios plus random accesses checked against a word-array memory model.
module tb_minx16_dbus_target;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ad;
   logic        ale, dle, rd, wr;
   logic [1:0]  stb;
   bit          sel;                // 1: instance with 2 wait states, 0: with 0

   int checks   = 0;
   int failures = 0;

   logic [15:0] mem [2][16];

   always #5 clk = ~clk;

   minx16_dbus_if b2 ();
   minx16_dbus_if b0 ();

   assign b2.ad_i  = ad;
   assign b2.stb_i = stb;
   assign b2.ale_i = ale & sel;
   assign b2.dle_i = dle & sel;
   assign b2.rd_i  = rd  & sel;
   assign b2.wr_i  = wr  & sel;
   assign b0.ad_i  = ad;
   assign b0.stb_i = stb;
   assign b0.ale_i = ale & ~sel;
   assign b0.dle_i = dle & ~sel;
   assign b0.rd_i  = rd  & ~sel;
   assign b0.wr_i  = wr  & ~sel;

   minx16_dbus_target #(.ADDR_W(4), .BASE_ADDR(16'hF000), .WAIT_STATES(2)) dut2 (
      .clk_i (clk), .rst_i (rst), .bus (b2.slave));
   minx16_dbus_target #(.ADDR_W(4), .BASE_ADDR(16'hF000), .WAIT_STATES(0)) dut0 (
      .clk_i (clk), .rst_i (rst), .bus (b0.slave));

   function automatic logic        o_rdy(); return sel ? b2.rdy_o    : b0.rdy_o;    endfunction
   function automatic logic        o_hit(); return sel ? b2.hit_o    : b0.hit_o;    endfunction
   function automatic logic [15:0] o_ad();  return sel ? b2.ad_o     : b0.ad_o;     endfunction
   function automatic logic [15:0] o_oeb(); return sel ? b2.ad_oeb_o : b0.ad_oeb_o; endfunction
   function automatic int lat_exp(); return sel ? 3 : 1; endfunction

   function automatic bit in_win(input logic [15:0] a);
      return a >= 16'hF000 && a <= 16'hF01F;
   endfunction

   function automatic int word_of(input logic [15:0] a);
      return int'(a - 16'hF000) / 2;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h (sel=%0d)", tag, obs, exp, sel);
      end
   endtask

   task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] s);
      int          n;
      logic [15:0] exp;
      ale = 1'b1; ad = a; tick(); ale = 1'b0; ad = '0;
      chk("hit", {31'b0, o_hit()}, {31'b0, in_win(a)});
      if (w) begin
         dle = 1'b1; ad = d; tick(); dle = 1'b0; ad = '0;
      end
      stb = s; rd = !w; wr = w;
      tick();
      n = 0;
      while (!o_rdy() && n < 40) begin tick(); n++; end
      if (!in_win(a)) begin
         chk("miss_no_rdy", n, 40);
         chk("miss_oeb", o_oeb(), 16'hFFFF);
      end else begin
         chk("latency", n, lat_exp());
         if (w) begin
            if (s[0]) mem[sel][word_of(a)][7:0]  = d[7:0];
            if (s[1]) mem[sel][word_of(a)][15:8] = d[15:8];
            chk("wr_oeb", o_oeb(), 16'hFFFF);
         end else begin
            exp = mem[sel][word_of(a)] & {{8{s[1]}}, {8{s[0]}}};
            chk("rd_data", o_ad(), exp);
            chk("rd_oeb", o_oeb(), 16'h0000);
            tick();
            chk("rd_hold", o_ad(), exp);
         end
         if (w) tick();
         chk("rdy_hold", {31'b0, o_rdy()}, 1);
      end
      rd = 1'b0; wr = 1'b0; stb = '0;
      tick();
      chk("rdy_release", {31'b0, o_rdy()}, 0);
      chk("oeb_release", o_oeb(), 16'hFFFF);
   endtask

   initial begin
      int          n;
      logic [15:0] a;
      rst = 1'b1; ad = '0; ale = 1'b0; dle = 1'b0; rd = 1'b0; wr = 1'b0; stb = '0; sel = 1'b1;
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         sel = bit'(s);
         chk("rst_ad", o_ad(), 16'h0000);
         chk("rst_oeb", o_oeb(), 16'hFFFF);
         chk("rst_rdy", {31'b0, o_rdy()}, 0);
         chk("rst_hit", {31'b0, o_hit()}, 0);
      end
      rst = 1'b0;
      tick();

      for (int s = 0; s < 2; s++) begin
         sel = bit'(s);
         for (int i = 0; i < 16; i++)
            access(1'b1, 16'hF000 + 16'(2 * i), 16'($urandom), 2'b11);
      end

      // Write then read back.
      sel = 1'b1;
      access(1'b1, 16'hF004, 16'hBEEF, 2'b11);
      access(1'b0, 16'hF004, 16'h0000, 2'b11);
      chk("t1_model", mem[1][2], 16'hBEEF);

      // Byte-strobed write and reads.
      access(1'b1, 16'hF006, 16'h1234, 2'b11);
      access(1'b1, 16'hF006, 16'h56AB, 2'b01);
      access(1'b0, 16'hF006, 16'h0000, 2'b11);
      access(1'b0, 16'hF006, 16'h0000, 2'b10);
      access(1'b1, 16'hF006, 16'h9999, 2'b00);
      access(1'b0, 16'hF006, 16'h0000, 2'b00);
      access(1'b0, 16'hF007, 16'h0000, 2'b11);

      // Miss: rd held 20 cycles outside the window.
      ale = 1'b1; ad = 16'hE004; tick(); ale = 1'b0; ad = '0;
      rd = 1'b1; stb = 2'b11;
      repeat (20) begin
         tick();
         chk("miss_rdy", {31'b0, o_rdy()}, 0);
         chk("miss_oeb", o_oeb(), 16'hFFFF);
         chk("miss_hit", {31'b0, o_hit()}, 0);
      end
      rd = 1'b0; stb = '0; tick();

      // Abort a write in WAIT with a new ale; F008 must keep its old value.
      ale = 1'b1; ad = 16'hF008; tick(); ale = 1'b0;
      dle = 1'b1; ad = 16'h0BAD; tick(); dle = 1'b0; ad = '0;
      wr = 1'b1; stb = 2'b11; tick(); tick();
      wr = 1'b0; stb = '0;
      access(1'b1, 16'hF00A, 16'hCAFE, 2'b11);
      access(1'b0, 16'hF008, 16'h0000, 2'b11);
      access(1'b0, 16'hF00A, 16'h0000, 2'b11);

      // Abort a read in ACK: bus released the cycle after ale.
      ale = 1'b1; ad = 16'hF00C; tick(); ale = 1'b0; ad = '0;
      rd = 1'b1; stb = 2'b11; tick();
      n = 0;
      while (!o_rdy() && n < 40) begin tick(); n++; end
      chk("ack_abort_lat", n, 3);
      rd = 1'b0; stb = '0; ale = 1'b1; ad = 16'hF00E; tick(); ale = 1'b0; ad = '0;
      chk("ack_abort_rdy", {31'b0, o_rdy()}, 0);
      chk("ack_abort_oeb", o_oeb(), 16'hFFFF);
      access(1'b0, 16'hF00E, 16'h0000, 2'b11);

      // Reset during ACK of a read.
      ale = 1'b1; ad = 16'hF004; tick(); ale = 1'b0; ad = '0;
      rd = 1'b1; stb = 2'b11; tick();
      n = 0;
      while (!o_rdy() && n < 40) begin tick(); n++; end
      chk("rst_ack_lat", n, 3);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_ack_rdy", {31'b0, o_rdy()}, 0);
      chk("rst_ack_oeb", o_oeb(), 16'hFFFF);
      chk("rst_ack_hit", {31'b0, o_hit()}, 0);
      rd = 1'b0; stb = '0; tick();
      access(1'b0, 16'hF004, 16'h0000, 2'b11);

      // Zero wait states; rd and wr together are ignored.
      sel = 1'b0;
      ale = 1'b1; ad = 16'hF004; tick(); ale = 1'b0; ad = '0;
      rd = 1'b1; wr = 1'b1; stb = 2'b11;
      repeat (6) begin
         tick();
         chk("rdwr_no_rdy", {31'b0, o_rdy()}, 0);
      end
      wr = 1'b0; tick();
      n = 0;
      while (!o_rdy() && n < 40) begin tick(); n++; end
      chk("ws0_lat", n, 1);
      chk("ws0_data", o_ad(), mem[0][2]);
      repeat (3) begin
         tick();
         chk("ws0_rdy_hold", {31'b0, o_rdy()}, 1);
      end
      rd = 1'b0; stb = '0; tick();
      chk("ws0_release", {31'b0, o_rdy()}, 0);

      // Random traffic on both instances.
      repeat (40) begin
         sel = bit'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            a = 16'($urandom);
            if (in_win(a)) a = a ^ 16'h8000;
         end else begin
            a = 16'hF000 + 16'($urandom_range(0, 31));
         end
         access(bit'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
